// File: rtl/cop_seq.sv
// cop_seq: accepts one mul/div coprocessor op at a time, starts the engine, times its latency,
// raises HI/LO or GPR write enables and stalls decode on hazards. Option macro: COP_DONE_HANDSHAKE_EN.
module cop_seq #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic [2:0] op,
    input  logic       wr_gpr,
    input  logic       wr_hilo,
    input  logic       rd_hilo,
    input  logic       cop_done,
    output logic       stall,
    output logic       busy,
    output logic       cop_start,
    output logic [2:0] cop_op,
    output logic       hilo_we,
    output logic       gpr_we
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10
    } state_t;

    localparam logic [2:0]       OP_NONE = 3'b111;
    localparam logic [2:0]       OP_DIV  = 3'b011;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    // Ops 000..011 are real coprocessor ops; 100..111 mean "none".
    function automatic logic is_cop_op(input logic [2:0] op_v);
        return (op_v[2] == 1'b0);
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       op_r, op_s;
    logic             gpr_l_r, gpr_l_s;
    logic             hilo_l_r, hilo_l_s;
    logic             valid_s;
    logic             run_done_s;
    logic             stall_s;
    logic             busy_r, cop_start_r, hilo_we_r, gpr_we_r;
    logic [2:0]       cop_op_r;

    assign valid_s = issue & is_cop_op(op);

`ifdef COP_DONE_HANDSHAKE_EN
    assign run_done_s = cop_done;
`else
    logic cop_done_unused_s;
    assign cop_done_unused_s = cop_done;
    assign run_done_s = (cnt_r == {CNT_W{1'b0}});
`endif

    // Next-state, counter and latched-op logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        gpr_l_s  = gpr_l_r;
        hilo_l_s = hilo_l_r;
        case (state_r)
            IDLE: begin
                if (valid_s) begin
                    state_s  = RUN;
                    op_s     = op;
                    gpr_l_s  = wr_gpr;
                    hilo_l_s = wr_hilo;
                    cnt_s    = (op == OP_DIV) ? DIV_CNT : MUL_CNT;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (run_done_s) begin
                    state_s = WB;
                end else begin
                    state_s = RUN;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            WB: begin
                state_s  = IDLE;
                op_s     = OP_NONE;
                gpr_l_s  = 1'b0;
                hilo_l_s = 1'b0;
                cnt_s    = {CNT_W{1'b0}};
            end
            default: begin
                state_s  = IDLE;
                op_s     = OP_NONE;
                gpr_l_s  = 1'b0;
                hilo_l_s = 1'b0;
                cnt_s    = {CNT_W{1'b0}};
            end
        endcase
    end

    // A MUL holds decode until its own WB; HI/LO writers only block readers and new ops.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = valid_s & wr_gpr;
            RUN:     stall_s = gpr_l_r | rd_hilo | valid_s;
            WB:      stall_s = ~gpr_l_r & (rd_hilo | valid_s);
            default: stall_s = 1'b0;
        endcase
    end

    // State, counter and latched flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= OP_NONE;
            gpr_l_r  <= 1'b0;
            hilo_l_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            op_r     <= op_s;
            gpr_l_r  <= gpr_l_s;
            hilo_l_r <= hilo_l_s;
        end
    end

    // Moore outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            cop_start_r <= 1'b0;
            cop_op_r    <= OP_NONE;
            hilo_we_r   <= 1'b0;
            gpr_we_r    <= 1'b0;
        end else begin
            busy_r      <= (state_s != IDLE);
            cop_start_r <= (state_r == IDLE) && (state_s == RUN);
            cop_op_r    <= (state_s == IDLE) ? OP_NONE : op_s;
            hilo_we_r   <= (state_s == WB) && hilo_l_s;
            gpr_we_r    <= (state_s == WB) && gpr_l_s;
        end
    end

    assign stall     = stall_s;
    assign busy      = busy_r;
    assign cop_start = cop_start_r;
    assign cop_op    = cop_op_r;
    assign hilo_we   = hilo_we_r;
    assign gpr_we    = gpr_we_r;

endmodule

// File: tb/tb_cop_seq.sv
// Directed bench for cop_seq: per-cycle vector tables plus hand-written multi-cycle sequences.
// Expectations hold for both the counter build and the COP_DONE_HANDSHAKE_EN build.
module tb_cop_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue, wr_gpr, wr_hilo, rd_hilo, cop_done;
    logic [2:0] op;
    logic       stall, busy, cop_start, hilo_we, gpr_we;
    logic [2:0] cop_op;
    logic       stall1, busy1, cop_start1, hilo_we1, gpr_we1;
    logic [2:0] cop_op1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // exp = {stall, busy, cop_start, cop_op[2:0], hilo_we, gpr_we}
    typedef struct {
        logic       iss;
        logic [2:0] op;
        logic       g;
        logic       h;
        logic       r;
        logic       d;
        logic [7:0] exp;
    } vec_t;

    vec_t main_q[$];
    vec_t lat1_q[$];

    cop_seq dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .op(op), .wr_gpr(wr_gpr),
        .wr_hilo(wr_hilo), .rd_hilo(rd_hilo), .cop_done(cop_done),
        .stall(stall), .busy(busy), .cop_start(cop_start), .cop_op(cop_op),
        .hilo_we(hilo_we), .gpr_we(gpr_we)
    );

    cop_seq #(.MUL_LAT(1), .DIV_LAT(2), .CNT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .issue(issue), .op(op), .wr_gpr(wr_gpr),
        .wr_hilo(wr_hilo), .rd_hilo(rd_hilo), .cop_done(cop_done),
        .stall(stall1), .busy(busy1), .cop_start(cop_start1), .cop_op(cop_op1),
        .hilo_we(hilo_we1), .gpr_we(gpr_we1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iss, input logic [2:0] o, input logic g, input logic h,
                                input logic r, input logic d, input logic s, input logic b,
                                input logic st, input logic [2:0] co, input logic hw, input logic gw);
        vec_t v;
        v.iss = iss; v.op = o; v.g = g; v.h = h; v.r = r; v.d = d;
        v.exp = {s, b, st, co, hw, gw};
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    task automatic set_in(input logic iss, input logic [2:0] o, input logic g, input logic h,
                          input logic r, input logic d);
        issue = iss; op = o; wr_gpr = g; wr_hilo = h; rd_hilo = r; cop_done = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] outs0();
        return {stall, busy, cop_start, cop_op, hilo_we, gpr_we};
    endfunction

    function automatic logic [7:0] outs1();
        return {stall1, busy1, cop_start1, cop_op1, hilo_we1, gpr_we1};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic       hseen;
        logic [7:0] e;

        // MULT with unrelated traffic, MUL hold, MADD then MSUBU, invalid ops (MUL_LAT=4)
        main_q.push_back(mk(1'b1,3'b000,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b111,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b000,1'b1,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,3'b000,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b000,1'b0,1'b1));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b001,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1,3'b001,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b010,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b001,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b010,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b001,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b010,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0,3'b001,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b010,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b001,1'b1,1'b0));
        main_q.push_back(mk(1'b1,3'b010,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,3'b010,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b010,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b010,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,3'b010,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b010,1'b1,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b101,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b110,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b000,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b1,3'b100,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        main_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));

        // LAT=1 instance: MULT then back-to-back MUL, cop_done in the first RUN cycle
        lat1_q.push_back(mk(1'b1,3'b000,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));
        lat1_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b1,3'b000,1'b0,1'b0));
        lat1_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'b000,1'b1,1'b0));
        lat1_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,3'b111,1'b0,1'b0));
        lat1_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,3'b000,1'b0,1'b0));
        lat1_q.push_back(mk(1'b1,3'b000,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,3'b000,1'b0,1'b1));
        lat1_q.push_back(mk(1'b0,3'b111,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,3'b111,1'b0,1'b0));

        rst_n = 1'b0;
        set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_values", outs0(), 8'b00011100);
        next_cycle();
        rst_n = 1'b1;

        foreach (main_q[i]) begin
            set_in(main_q[i].iss, main_q[i].op, main_q[i].g, main_q[i].h, main_q[i].r, main_q[i].d);
            @(negedge clk);
            check($sformatf("main[%0d]", i), outs0(), main_q[i].exp);
            next_cycle();
        end

        // DIV at 0, MFHI from 1: {stall,busy,hilo_we}
        set_in(1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("divmfhi[0]", {5'b00000, stall, busy, hilo_we}, 8'b00000000);
        next_cycle();
        for (int c = 1; c <= 34; c++) begin
            set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b1, (c == 32));
            @(negedge clk);
            check($sformatf("divmfhi[%0d]", c), {5'b00000, stall, busy, hilo_we},
                  {5'b00000, (c <= 33), (c <= 33), (c == 33)});
            next_cycle();
        end

        // Reset at cycle 10 of a DIV aborts it with no write enable
        set_in(1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        hseen = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (hilo_we) hseen = 1'b1;
            next_cycle();
        end
        check("busy_before_abort", {7'b0000000, busy}, 8'b00000001);
        rst_n = 1'b0;
        #1;
        check("abort_in_reset", outs0(), 8'b00011100);
        next_cycle();
        rst_n = 1'b1;
        set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("after_abort", outs0(), 8'b00011100);
        next_cycle();
        set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hilo_we) hseen = 1'b1;
            next_cycle();
        end
        check("no_hilo_we_after_abort", {7'b0000000, hseen}, 8'b00000000);

        // cop_done pulse at cycle 3 of a DIV: honored only in the handshake build
        do_reset();
        set_in(1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1);
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            set_in(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, (c == 3));
            @(negedge clk);
`ifdef COP_DONE_HANDSHAKE_EN
            e = {6'b000000, (c <= 4), (c == 4)};
`else
            e = 8'b00000010;
`endif
            check($sformatf("cop_done[%0d]", c), {6'b000000, busy, hilo_we}, e);
            next_cycle();
        end

        do_reset();
        foreach (lat1_q[i]) begin
            set_in(lat1_q[i].iss, lat1_q[i].op, lat1_q[i].g, lat1_q[i].h, lat1_q[i].r, lat1_q[i].d);
            @(negedge clk);
            check($sformatf("lat1[%0d]", i), outs1(), lat1_q[i].exp);
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cop_seq.md
# cop_seq

Multi-cycle sequencer for the multiply/divide coprocessor. Sits between the decode-stage coprocessor op decoder and the iterative mul/div engine. Accepts one coprocessor operation at a time, starts the engine, and counts its latency. It then raises the HI/LO or GPR write enable and stalls the pipeline on structural or data hazards: a second coprocessor op, an MFHI/MFLO read, or a MUL waiting for its result.

## Interface
Parameters:
- MUL_LAT, 4: engine cycles for op 000/001/010 (≥1)
- DIV_LAT, 32: engine cycles for op 011 (≥1)
- CNT_W, 6: counter width; must hold max(MUL_LAT, DIV_LAT)-1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue  in  1  decode stage holds a valid instruction
- op  in  3  decoder op: 000 MULT/MUL, 001 MADD, 010 MSUBU, 011 DIV, 111 none; 100–110 treated as none
- wr_gpr  in  1  result goes to GPR (MUL)
- wr_hilo  in  1  result goes to HI/LO
- rd_hilo  in  1  decode-stage instruction reads HI/LO (MFHI/MFLO)
- cop_done  in  1  engine completion; used only with COP_DONE_HANDSHAKE_EN
- stall  out  1  hold decode stage and earlier
- busy  out  1  state ≠ IDLE
- cop_start  out  1  one-cycle engine start pulse
- cop_op  out  3  latched op to engine
- hilo_we  out  1  HI/LO write enable
- gpr_we  out  1  GPR write enable for the MUL result

## Operation
- Reset values:
  - stall, busy, cop_start, hilo_we, gpr_we = 0
  - cop_op = 111
  - counter = 0
  - state = IDLE
  - latched flags = 0
- Valid op: issue=1 and op ∈ {000, 001, 010, 011}.
- States:
  - IDLE: on a valid op (accept cycle):
    - latch op, wr_gpr, wr_hilo
    - load counter with MUL_LAT-1 (op 000/001/010) or DIV_LAT-1 (op 011)
    - go to RUN
  - RUN: counter decrements each cycle; when counter = 0, go to WB.
  - WB: one cycle, then go to IDLE.
- Outputs (Moore, registered):
  - cop_start = 1 in the first RUN cycle only.
  - cop_op holds the latched op from RUN through WB, and returns to 111 in IDLE.
  - hilo_we = latched wr_hilo, and gpr_we = latched wr_gpr, both during WB only.
- stall (combinational) = 1 when any of:
  - IDLE, valid op with wr_gpr=1. The MUL is held in decode.
  - RUN, and any of: latched wr_gpr, rd_hilo, or a valid op.
  - WB with latched wr_gpr=0, and rd_hilo or a valid op. HI/LO is written this cycle, so readers or new ops wait one more cycle.
- In WB with latched wr_gpr=1, stall = 0. The held MUL advances with gpr_we=1.
- HI/LO-only ops (MULT/MADD/MSUBU/DIV) do not stall unrelated instructions; the pipeline runs ahead.
- A valid op presented while busy is not accepted. It is held by stall and accepted in the IDLE cycle after WB.
- Reset mid-operation:
  - Abort immediately to IDLE with reset values.
  - No write enable is produced.
  - The engine is left unstarted or its result is discarded.

## Timing
- Accept at cycle T: RUN spans T+1..T+LAT, WB at T+LAT+1, IDLE at T+LAT+2.
- Earliest next accept: T+LAT+2. Back-to-back throughput is LAT+2 cycles.
- MUL stalls decode for cycles T..T+LAT and is released at T+LAT+1 together with gpr_we.
- MFHI/MFLO behind a HI/LO op is released at T+LAT+2, the first cycle after hilo_we.
- LAT=1: a single RUN cycle, which also carries cop_start.

## Configuration
- COP_DONE_HANDSHAKE_EN defined:
  - RUN exits to WB on the cycle after cop_done is sampled 1. The counter is not used and latency is engine-determined.
  - cop_done is ignored outside RUN.
  - cop_done=1 in the first RUN cycle (alongside cop_start) is honored.
- Undefined: the counter sets latency as above and cop_done is ignored.

## Test plan
- Reset during RUN of DIV (cycle T+10) -> the next cycle shows IDLE, all outputs 0, cop_op=111, and no hilo_we ever pulses.
- MULT (op=000, wr_hilo=1), MUL_LAT=4, accepted at T=5:
  - cop_start=1 at 6
  - hilo_we=1 at 10 only
  - busy 6..10
  - stall=0 throughout for unrelated instructions
- MUL (op=000, wr_gpr=1) at T=5:
  - stall=1 at 5..9
  - stall=0 with gpr_we=1 at 10
  - IDLE at 11
- DIV at T=0 followed by MFHI (rd_hilo=1) from cycle 1:
  - stall=1 at 1..33
  - hilo_we=1 at 33
  - stall=0 at 34
- MADD at T=0, then MSUBU presented at cycle 2 (MUL_LAT=4):
  - MSUBU stalled at 2..5, accepted at 6
  - cop_start at 7, cop_op=010 at 7..11
- op=101 with issue=1 -> not accepted: busy=0, stall=0, cop_start=0; with COP_DONE_HANDSHAKE_EN, DIV exits RUN one cycle after a cop_done pulse at cycle 3 (WB at 4).
